fb_write_arbiter: RTL and testbench

- Owns write port A of the 320x240 8-bit frame buffer in the eth_refclk domain.
- Shares port A between two requesters:
  - the frame_packager pixel stream, which has priority and can never be stalled because RMII has no backpressure;
  - an internal clear engine that sweeps every address with CLEAR_VAL when a clear is requested, for example a lightboard erase.
- Also tracks frame boundaries and reports completed frames to downstream display and status logic.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_clear_engine.sv | 67 ++++++
 rtl/fb_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame buffer geometry, pixel/address types and the clear FSM state encoding.
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 8;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] fb_pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Clear sweep FSM: walks the pointer over every frame buffer address, advancing only on granted cycles.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int DEPTH  = FB_DEPTH,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                // start is deliberately not looked at here: a sweep is never restarted mid-way
                if (grant) begin
                    if ({1'b0, ptr_q} == LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign req  = (state_q == CLEAR);
    assign busy = (state_q == CLEAR);
    assign ptr  = ptr_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame buffer port A owner: pixel stream has absolute priority, clear engine fills idle slots, frames are tracked.
// Optional statistics counters are enabled with the FB_ARB_STATS_EN macro.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int                 DEPTH     = FB_DEPTH,
    parameter int                 ADDR_W    = FB_ADDR_W,
    parameter int                 DATA_W    = FB_DATA_W,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              px_valid,
    input  logic [ADDR_W-1:0] px_addr,
    input  logic [DATA_W-1:0] px_data,
    input  logic              clr_req,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              frame_done,
    output logic              frame_full,
    output logic              addr_err
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_drops
`endif
);

    // ADDR_W+1 bits so that DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);

    logic              eng_req, eng_busy, eng_done, grant;
    logic [ADDR_W-1:0] eng_ptr;

    logic              px_ok, px_bad, px_last;
    logic [ADDR_W:0]   cnt_inc;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              cdone_q, cdone_d;
    logic              fdone_q, fdone_d;
    logic              ffull_q, ffull_d;
    logic              aerr_q, aerr_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;

    fb_clear_engine #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .start (clr_req),
        .grant (grant),
        .req   (eng_req),
        .ptr   (eng_ptr),
        .busy  (eng_busy),
        .done  (eng_done)
    );

    assign px_ok   = px_valid & ({1'b0, px_addr} < DEPTH_W);
    assign px_bad  = px_valid & ~px_ok;
    assign px_last = px_ok & ({1'b0, px_addr} == LAST_W);
    // a dropped out-of-range pixel leaves the slot free for the sweep
    assign grant   = eng_req & ~px_ok;
    assign cnt_inc = {1'b0, pix_cnt_q} + (ADDR_W+1)'(1);

    always_comb begin
        we_d      = px_ok | grant;
        addr_d    = addr_q;
        din_d     = din_q;
        cdone_d   = eng_done;
        aerr_d    = px_bad;
        fdone_d   = px_last;
        ffull_d   = px_last & (cnt_inc == DEPTH_W);
        pix_cnt_d = pix_cnt_q;
        if (px_ok) begin
            addr_d = px_addr;
            din_d  = px_data;
        end else if (grant) begin
            addr_d = eng_ptr;
            din_d  = CLEAR_VAL;
        end
        if (px_last) begin
            pix_cnt_d = '0;
        end else if (px_ok && (cnt_inc <= DEPTH_W) && !cnt_inc[ADDR_W]) begin
            pix_cnt_d = cnt_inc[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            cdone_q   <= 1'b0;
            fdone_q   <= 1'b0;
            ffull_q   <= 1'b0;
            aerr_q    <= 1'b0;
            pix_cnt_q <= '0;
        end else begin
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            cdone_q   <= cdone_d;
            fdone_q   <= fdone_d;
            ffull_q   <= ffull_d;
            aerr_q    <= aerr_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_din     = din_q;
    assign clr_busy   = eng_busy;
    assign clr_done   = cdone_q;
    assign frame_done = fdone_q;
    assign frame_full = ffull_q;
    assign addr_err   = aerr_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] frames_q, frames_d;
    logic [15:0] drops_q, drops_d;

    always_comb begin
        frames_d = frames_q;
        drops_d  = drops_q;
        if (fdone_d && ffull_d && (frames_q != 16'hFFFF)) begin
            frames_d = frames_q + 16'd1;
        end
        // an out-of-range drop and a frame end cannot coincide: both need the single px slot
        if ((aerr_d || (fdone_d && !ffull_d)) && (drops_q != 16'hFFFF)) begin
            drops_d = drops_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            frames_q <= frames_d;
            drops_q  <= drops_d;
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a reduced 200-word buffer (ADDR_W=8 leaves room for out-of-range addresses).
module tb_fb_write_arbiter;

    localparam int          DEPTH  = 200;
    localparam int          ADDR_W = 8;
    localparam int          DATA_W = 8;
    localparam logic [7:0]  CLRV   = 8'h3C;

    logic              clk;
    logic              rst_n;
    logic              px_valid;
    logic [ADDR_W-1:0] px_addr;
    logic [DATA_W-1:0] px_data;
    logic              clr_req;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_din;
    logic              clr_busy;
    logic              clr_done;
    logic              frame_done;
    logic              frame_full;
    logic              addr_err;
`ifdef FB_ARB_STATS_EN
    logic [15:0]       stat_frames;
    logic [15:0]       stat_drops;
`endif

    fb_write_arbiter #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLEAR_VAL (CLRV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .px_valid   (px_valid),
        .px_addr    (px_addr),
        .px_data    (px_data),
        .clr_req    (clr_req),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_din     (fb_din),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .frame_done (frame_done),
        .frame_full (frame_full),
        .addr_err   (addr_err)
`ifdef FB_ARB_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_drops  (stat_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pcnt  = 0;
    int clr_hits[DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input logic v, input int a, input logic [7:0] d);
        px_valid = v;
        px_addr  = ADDR_W'(a);
        px_data  = d;
    endtask

    // reference frame tracker: returns the expected frame_done/frame_full for one accepted write
    task automatic model_px(input int a, output logic fd, output logic ff);
        fd = 1'b0;
        ff = 1'b0;
        if (a == DEPTH - 1) begin
            fd   = 1'b1;
            ff   = (pcnt + 1 == DEPTH);
            pcnt = 0;
        end else if (pcnt < DEPTH) begin
            pcnt++;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},    32'(fb_we),      32'd0);
        chk({tag, "_addr"},  32'(fb_addr),    32'd0);
        chk({tag, "_din"},   32'(fb_din),     32'd0);
        chk({tag, "_busy"},  32'(clr_busy),   32'd0);
        chk({tag, "_cdone"}, 32'(clr_done),   32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
        chk({tag, "_ffull"}, 32'(frame_full), 32'd0);
        chk({tag, "_aerr"},  32'(addr_err),   32'd0);
    endtask

    initial begin
        logic fd, ff;
        int   exp_ptr, pa, k, bad_addr;
        logic [7:0] pd;

        rst_n = 1'b0;
        clr_req = 1'b0;
        drive_px(1'b0, 0, 8'h00);
        #2;
        chk_idle_outputs("reset");
`ifdef FB_ARB_STATS_EN
        chk("reset_stat_frames", 32'(stat_frames), 32'd0);
        chk("reset_stat_drops",  32'(stat_drops),  32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_busy", 32'(clr_busy), 32'd0);

        // full frame 0..DEPTH-1, data = addr
        for (int a = 0; a < DEPTH; a++) begin
            drive_px(1'b1, a, 8'(a));
            model_px(a, fd, ff);
            step();
            chk("frame_we",    32'(fb_we),      32'd1);
            chk("frame_addr",  32'(fb_addr),    32'(a));
            chk("frame_din",   32'(fb_din),     32'(a & 8'hFF));
            chk("frame_fdone", 32'(frame_done), 32'(fd));
            chk("frame_ffull", 32'(frame_full), 32'(ff));
        end
        chk("frame_last_full", 32'(ff), 32'd1);
        drive_px(1'b0, 0, 8'h00);
        step();
        chk("hold_we",    32'(fb_we),      32'd0);
        chk("hold_addr",  32'(fb_addr),    32'(DEPTH - 1));
        chk("hold_din",   32'(fb_din),     32'((DEPTH - 1) & 8'hFF));
        chk("hold_fdone", 32'(frame_done), 32'd0);

        // out-of-range pixel writes are dropped
        drive_px(1'b1, DEPTH, 8'hAA);
        step();
        chk("oor1_we",   32'(fb_we),    32'd0);
        chk("oor1_aerr", 32'(addr_err), 32'd1);
        drive_px(1'b1, 255, 8'hBB);
        step();
        chk("oor2_we",   32'(fb_we),    32'd0);
        chk("oor2_aerr", 32'(addr_err), 32'd1);
        chk("oor2_addr", 32'(fb_addr),  32'(DEPTH - 1));
        drive_px(1'b0, 0, 8'h00);
        step();
        chk("oor_aerr_clear", 32'(addr_err), 32'd0);
`ifdef FB_ARB_STATS_EN
        chk("stat_frames_1", 32'(stat_frames), 32'd1);
        chk("stat_drops_2",  32'(stat_drops),  32'd2);
`endif

        // plain clear on an idle bus
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("clr_busy_start", 32'(clr_busy), 32'd1);
        chk("clr_we_start",   32'(fb_we),    32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("clr_we",    32'(fb_we),    32'd1);
            chk("clr_addr",  32'(fb_addr),  32'(i));
            chk("clr_din",   32'(fb_din),   32'(CLRV));
            chk("clr_done",  32'(clr_done), 32'(i == DEPTH - 1));
            chk("clr_busy",  32'(clr_busy), 32'(i != DEPTH - 1));
        end
        step();
        chk("clr_after_we",   32'(fb_we),    32'd0);
        chk("clr_after_done", 32'(clr_done), 32'd0);
        chk("clr_after_addr", 32'(fb_addr),  32'(DEPTH - 1));
        chk("clr_after_din",  32'(fb_din),   32'(CLRV));

        // clear interleaved with pixel writes on alternating cycles, plus a redundant clr_req mid-sweep
        for (int i = 0; i < DEPTH; i++) clr_hits[i] = 0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("alt_busy_start", 32'(clr_busy), 32'd1);
        exp_ptr = 0;
        pa = 100;
        k = 0;
        while (exp_ptr < DEPTH && k < 3 * DEPTH) begin
            clr_req = (k == 51);
            if (k % 2 == 0) begin
                pd = 8'(pa) ^ 8'h5A;
                drive_px(1'b1, pa, pd);
                model_px(pa, fd, ff);
                step();
                chk("alt_px_we",    32'(fb_we),      32'd1);
                chk("alt_px_addr",  32'(fb_addr),    32'(pa));
                chk("alt_px_din",   32'(fb_din),     32'(pd));
                chk("alt_px_fdone", 32'(frame_done), 32'(fd));
                chk("alt_px_ffull", 32'(frame_full), 32'(ff));
                chk("alt_px_cdone", 32'(clr_done),   32'd0);
                pa = (pa == DEPTH - 1) ? 100 : pa + 1;
            end else begin
                drive_px(1'b0, 0, 8'h00);
                step();
                chk("alt_clr_we",    32'(fb_we),      32'd1);
                chk("alt_clr_addr",  32'(fb_addr),    32'(exp_ptr));
                chk("alt_clr_din",   32'(fb_din),     32'(CLRV));
                chk("alt_clr_cdone", 32'(clr_done),   32'(exp_ptr == DEPTH - 1));
                chk("alt_clr_fdone", 32'(frame_done), 32'd0);
                if (fb_addr < DEPTH) clr_hits[fb_addr]++;
                exp_ptr++;
            end
            k++;
        end
        clr_req = 1'b0;
        drive_px(1'b0, 0, 8'h00);
        chk("alt_grants", 32'(exp_ptr), 32'(DEPTH));
        chk("alt_cycles", 32'(k), 32'(2 * DEPTH));
        bad_addr = 0;
        for (int i = 0; i < DEPTH; i++) if (clr_hits[i] != 1) bad_addr++;
        chk("alt_each_once", 32'(bad_addr), 32'd0);
        step();
        chk("alt_busy_end", 32'(clr_busy), 32'd0);
        chk("alt_we_end",   32'(fb_we),    32'd0);
`ifdef FB_ARB_STATS_EN
        chk("stat_frames_alt", 32'(stat_frames), 32'd1);
        chk("stat_drops_alt",  32'(stat_drops),  32'd4);
`endif

        // fresh reset, short frame, full frame, repeated last address
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pcnt = 0;
        step();
        for (int a = DEPTH - 20; a < DEPTH; a++) begin
            drive_px(1'b1, a, 8'(a + 1));
            step();
            chk("short_fdone", 32'(frame_done), 32'(a == DEPTH - 1));
            chk("short_ffull", 32'(frame_full), 32'd0);
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive_px(1'b1, a, 8'(a));
            step();
            chk("full2_fdone", 32'(frame_done), 32'(a == DEPTH - 1));
            chk("full2_ffull", 32'(frame_full), 32'(a == DEPTH - 1));
        end
        drive_px(1'b1, DEPTH - 1, 8'h77);
        step();
        chk("repeat_fdone", 32'(frame_done), 32'd1);
        chk("repeat_ffull", 32'(frame_full), 32'd0);
        chk("repeat_din",   32'(fb_din),     32'h77);
        drive_px(1'b0, 0, 8'h00);
        step();
        chk("repeat_fdone_clear", 32'(frame_done), 32'd0);
`ifdef FB_ARB_STATS_EN
        chk("stat_frames_3", 32'(stat_frames), 32'd1);
        chk("stat_drops_3",  32'(stat_drops),  32'd2);
`endif

        // asynchronous reset in the middle of a sweep
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("midclr_addr", 32'(fb_addr), 32'd9);
        chk("midclr_busy", 32'(clr_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        step();
        chk("rst_hold_cdone", 32'(clr_done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_rel_busy", 32'(clr_busy), 32'd0);
        chk("rst_rel_we",   32'(fb_we),    32'd0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("restart_busy", 32'(clr_busy), 32'd1);
        step();
        chk("restart_we",   32'(fb_we),   32'd1);
        chk("restart_addr", 32'(fb_addr), 32'd0);
        chk("restart_din",  32'(fb_din),  32'(CLRV));
        step();
        chk("restart_addr1", 32'(fb_addr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
